// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex-to-segment mapping for the scan driver.
// Codes are active-low: bit7=a .. bit1=g, bit0=dp.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DP_BIT  = 0;

  localparam logic [7:0] SEG_CODES [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib, input logic dp);
    logic [7:0] code;
    code = SEG_CODES[nib];
    if (dp) begin
      code[DP_BIT] = 1'b0;
    end
    return code;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point + blank to active-low segment pattern.
// A blanked digit drives every segment, including dp, dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : hex2seg(nib_i, dp_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with a tear-free display register.
// Define SEG7_LZS_EN to enable leading-zero suppression on top of blank_mask.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic [IW-1:0]            idx_q, idx_d;

  logic                     pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0][3:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]        pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]        pend_blank_q, pend_blank_d;

  logic [DIGITS-1:0][3:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]        disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]        disp_blank_q, disp_blank_d;

  logic [7:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;

  logic                     tick;
  logic                     frame_end;
  logic                     accept;
  logic                     commit;
  logic [DIGITS-1:0]        lz_mask;
  logic [DIGITS-1:0]        eff_blank;
  logic                     cur_blank;

  assign tick       = (pcnt_q == PCNT_LAST);
  assign frame_end  = tick && (idx_q == IDX_LAST);
  assign ready      = ~pend_vld_q;
  // Accept and commit are mutually exclusive: a load taken on the frame
  // boundary waits for the following boundary.
  assign accept     = load & ~pend_vld_q;
  assign commit     = frame_end & pend_vld_q;

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (accept) begin
      pend_vld_d   = 1'b1;
      pend_val_d   = value;
      pend_dp_d    = dp_mask;
      pend_blank_d = blank_mask;
    end else if (commit) begin
      pend_vld_d   = 1'b0;
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end
  end

`ifdef SEG7_LZS_EN
  logic lz_run;
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run & (disp_val_q[i] == 4'h0) & ~disp_dp_q[i];
      lz_mask[i] = lz_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign eff_blank = disp_blank_q | lz_mask;
  assign cur_blank = eff_blank[idx_q];

  seg7_decode u_decode (
    .nib_i   (disp_val_q[idx_q]),
    .dp_i    (disp_dp_q[idx_q]),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  always_comb begin
    an_d = ~(DIGITS'(1) << idx_q);
    if (cur_blank) begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      pend_vld_q   <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pend_vld_q   <= pend_vld_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4 (16-clock frame).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        ready;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .ready      (ready),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_fd_seen"}, {15'd0, frame_done}, 16'd1);
  endtask

  // Call in the cycle right after frame_done; checks all 16 cycles of the next frame.
  task automatic check_slots(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input logic [3:0] blk);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      if (blk[d]) exp_an = 4'b1111;
      for (int c = 0; c < 4; c++) begin
        cyc();
        chk($sformatf("%s_d%0d_c%0d_seg", tag, d, c), {8'd0, seg}, {8'd0, exp_seg[d]});
        chk($sformatf("%s_d%0d_c%0d_an", tag, d, c), {12'd0, an}, {12'd0, exp_an});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0;
    repeat (3) cyc();
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {8'd0, seg}, 16'h00FF);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_fd", {15'd0, frame_done}, 16'd0);

    rst = 1'b0;
    cyc();
    chk("first_an", {12'd0, an}, 16'h000E);
    chk("first_seg", {8'd0, seg}, 16'h0003);
    chk("first_ready", {15'd0, ready}, 16'd1);

    for (int k = 1; k <= 30; k++) begin
      cyc();
      chk($sformatf("fd_k%0d", k), {15'd0, frame_done}, {15'd0, (k % 16 == 14)});
    end

    // Load offered in the frame_done cycle: must wait a whole frame.
    load = 1'b1; value = 16'h1A3F; dp_mask = 4'b0010; blank_mask = 4'b0000;
    cyc();
    load = 1'b0;
    chk("ld1_ready_low", {15'd0, ready}, 16'd0);
    cyc();
    chk("ld1_no_midframe", {8'd0, seg}, 16'h0003);
    cyc();
    load = 1'b1; value = 16'hFFFF; dp_mask = 4'b0000;
    cyc();
    load = 1'b0;
    chk("ign_ready_low", {15'd0, ready}, 16'd0);
    wait_fd("ld1");
    chk("ld1_ready_at_fd", {15'd0, ready}, 16'd0);
    cyc();
    chk("ld1_ready_high", {15'd0, ready}, 16'd1);
    check_slots("ld1", 8'h71, 8'h0C, 8'h11, 8'h9F, 4'b0000);

    load = 1'b1; value = 16'h1A3F; dp_mask = 4'b0010; blank_mask = 4'b0100;
    cyc();
    load = 1'b0;
    chk("blk_ready_low", {15'd0, ready}, 16'd0);
    wait_fd("blk");
    cyc();
    chk("blk_ready_high", {15'd0, ready}, 16'd1);
    check_slots("blk", 8'h71, 8'h0C, 8'hFF, 8'h9F, 4'b0100);

    load = 1'b1; value = 16'h0050; dp_mask = 4'b0000; blank_mask = 4'b0000;
    cyc();
    load = 1'b0;
    wait_fd("v0050");
    cyc();
`ifdef SEG7_LZS_EN
    check_slots("v0050", 8'h03, 8'h49, 8'hFF, 8'hFF, 4'b1100);
`else
    check_slots("v0050", 8'h03, 8'h49, 8'h03, 8'h03, 4'b0000);
`endif

    load = 1'b1; value = 16'h0000; dp_mask = 4'b0000; blank_mask = 4'b0000;
    cyc();
    load = 1'b0;
    wait_fd("v0000");
    cyc();
`ifdef SEG7_LZS_EN
    check_slots("v0000", 8'h03, 8'hFF, 8'hFF, 8'hFF, 4'b1110);
`else
    check_slots("v0000", 8'h03, 8'h03, 8'h03, 8'h03, 4'b0000);
`endif

    // Reset two cycles after an accepted load must drop the pending data.
    load = 1'b1; value = 16'h8888; dp_mask = 4'b1111; blank_mask = 4'b0000;
    cyc();
    load = 1'b0;
    chk("prst_ready_low", {15'd0, ready}, 16'd0);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("prst_an", {12'd0, an}, 16'h000F);
    chk("prst_seg", {8'd0, seg}, 16'h00FF);
    chk("prst_ready", {15'd0, ready}, 16'd1);
    rst = 1'b0;
    cyc();
    chk("prst_first_an", {12'd0, an}, 16'h000E);
    chk("prst_first_seg", {8'd0, seg}, 16'h0003);
    wait_fd("prst");
    cyc();
`ifdef SEG7_LZS_EN
    check_slots("prst", 8'h03, 8'hFF, 8'hFF, 8'hFF, 4'b1110);
`else
    check_slots("prst", 8'h03, 8'h03, 8'h03, 8'h03, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
